// File: rtl/regfile_wb_ctrl.sv
// Register file write-back controller: buffers write-back requests in an
// in-order queue, drains them onto the reg_file write port, and forwards pending data.
module regfile_wb_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wb_valid,
    output logic                         wb_ready,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         wr_stall,
    output logic                         reg_write,
    output logic [ADDR_W-1:0]            rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    input  logic [ADDR_W-1:0]            rs1_addr_in,
    input  logic [ADDR_W-1:0]            rs2_addr_in,
    output logic [ADDR_W-1:0]            rs1_addr,
    output logic [ADDR_W-1:0]            rs2_addr,
    input  logic [DATA_W-1:0]            rs1_data_rf,
    input  logic [DATA_W-1:0]            rs2_data_rf,
    output logic [DATA_W-1:0]            rs1_data,
    output logic [DATA_W-1:0]            rs2_data,
    output logic [$clog2(DEPTH+1)-1:0]   pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic full;
    logic empty;
    logic enq;
    logic deq;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign wb_ready = !full;
    assign pending  = count;

    // x0 writes complete the handshake but never occupy a queue slot
    assign enq = wb_valid && wb_ready && (wb_addr != '0);
    assign deq = !empty && !wr_stall;

    assign rs1_addr = rs1_addr_in;
    assign rs2_addr = rs2_addr_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[wr_ptr] <= wb_addr;
            q_data[wr_ptr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
        end else if (deq) begin
            reg_write <= 1'b1;
            rd_addr   <= q_addr[rd_ptr];
            rd_data   <= q_data[rd_ptr];
        end else begin
            reg_write <= 1'b0;
        end
    end

    // Scan oldest to youngest so the last match (newest write) wins over
    // older entries and over the output register.
    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] a,
                                              input logic [DATA_W-1:0] rf);
        logic [DATA_W-1:0] r;
        logic [PTR_W-1:0]  idx;
        r = rf;
        if (reg_write && (rd_addr == a)) r = rd_data;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((i < 32'(count)) && (q_addr[idx] == a)) r = q_data[idx];
        end
        if (a == '0) r = '0;
        return r;
    endfunction

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        rs1_data = fwd(rs1_addr_in, rs1_data_rf);
        rs2_data = fwd(rs2_addr_in, rs2_data_rf);
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: accepted writes queue expected reg_file
// writes; a monitor pops and compares every reg_write pulse.
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wr_stall;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr_in, rs2_addr_in, rs1_addr, rs2_addr;
    logic [31:0] rs1_data_rf, rs2_data_rf, rs1_data, rs2_data;
    logic [2:0]  pending;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    regfile_wb_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .wr_stall(wr_stall), .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data_rf(rs1_data_rf), .rs2_data_rf(rs2_data_rf),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .pending(pending)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance with valid low.
    task automatic send(input logic [4:0] a, input logic [31:0] d);
        int unsigned n = 0;
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        while (!wb_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!wb_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got wb_ready=0 expected 1 within 50 cycles");
        end else if (a != 5'd0) begin
            exp_q.push_back({a, d});
        end
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    // Monitor: every issued write must match the head of the scoreboard.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && reg_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected none",
                             rd_addr, rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_addr", 32'(rd_addr), 32'(e[36:32]));
                    chk("mon_data", rd_data, e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        rst_n = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wr_stall = 1'b0;
        rs1_addr_in = '0; rs2_addr_in = '0; rs1_data_rf = '0; rs2_data_rf = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset / idle
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_wb_ready", 32'(wb_ready), 32'd1);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        rs1_addr_in = 5'd3; rs1_data_rf = 32'hCAFE_0003;
        #1;
        chk("idle_rs1_addr", 32'(rs1_addr), 32'd3);
        chk("idle_rs1_rf", rs1_data, 32'hCAFE_0003);

        // Single write, latency and forwarding
        rs1_addr_in = 5'd5; rs1_data_rf = 32'h1111_1111;
        send(5'd5, 32'hDEAD_BEEF);
        chk("single_pend", 32'(pending), 32'd1);
        chk("single_noissue_yet", 32'(reg_write), 32'd0);
        chk("single_fwd_queue", rs1_data, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("single_reg_write", 32'(reg_write), 32'd1);
        chk("single_rd_addr", 32'(rd_addr), 32'd5);
        chk("single_rd_data", rd_data, 32'hDEAD_BEEF);
        chk("single_fwd_outreg", rs1_data, 32'hDEAD_BEEF);
        @(negedge clk);

        // x0 write is accepted and dropped
        chk("x0_ready", 32'(wb_ready), 32'd1);
        send(5'd0, 32'h1234);
        chk("x0_pend", 32'(pending), 32'd0);
        rs2_addr_in = 5'd0; rs2_data_rf = 32'hFFFF_FFFF;
        #1;
        chk("x0_rs2_zero", rs2_data, 32'd0);
        repeat (2) @(negedge clk);
        chk("x0_pend2", 32'(pending), 32'd0);

        // Fill under stall, then drain in order
        wr_stall = 1'b1;
        for (int unsigned i = 1; i <= 4; i++) send(5'(i), 32'(i * 16));
        chk("full_pend", 32'(pending), 32'd4);
        chk("full_ready", 32'(wb_ready), 32'd0);
        rs1_addr_in = 5'd2; rs1_data_rf = '0;
        #1;
        chk("full_fwd_mid", rs1_data, 32'h20);
        wr_stall = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h50;
        for (int unsigned k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("drain_ready", 32'(wb_ready), 32'd1);
                chk("drain_pend", 32'(pending), 32'd3);
                exp_q.push_back({5'd5, 32'h50});
            end
            if (k == 1) wb_valid = 1'b0;
            chk("drain_consec_we", 32'(reg_write), 32'd1);
            chk("drain_consec_addr", 32'(rd_addr), k + 1);
        end
        @(negedge clk);

        // Same address twice: newest value forwarded, both issued in order
        wr_stall = 1'b1;
        send(5'd3, 32'h0A);
        send(5'd3, 32'h0B);
        rs1_addr_in = 5'd3; rs1_data_rf = 32'h33;
        #1;
        chk("dup_fwd_newest", rs1_data, 32'h0B);
        wr_stall = 1'b0;
        @(negedge clk);
        chk("dup_first_data", rd_data, 32'h0A);
        chk("dup_fwd_over_outreg", rs1_data, 32'h0B);
        repeat (2) @(negedge clk);

        // Reset with three writes pending
        wr_stall = 1'b1;
        send(5'd6, 32'h66);
        send(5'd7, 32'h77);
        send(5'd8, 32'h88);
        chk("rstmid_pend_before", 32'(pending), 32'd3);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rstmid_pend", 32'(pending), 32'd0);
        chk("rstmid_rd_data", rd_data, 32'd0);
        chk("rstmid_rd_addr", 32'(rd_addr), 32'd0);
        wr_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rstmid_pend_after", 32'(pending), 32'd0);

        // Sustained one-per-cycle stream
        for (int unsigned i = 0; i < 4; i++) begin
            wb_valid = 1'b1; wb_addr = 5'(10 + i); wb_data = 32'hA000 + i;
            if (wb_ready) exp_q.push_back({wb_addr, wb_data});
            else chk("stream_ready", 32'(wb_ready), 32'd1);
            @(negedge clk);
            if (i > 0) chk("stream_we", 32'(reg_write), 32'd1);
        end
        wb_valid = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
